// File: rtl/seq_restoring_divider.sv
// rtl/seq_restoring_divider.sv - iterative unsigned restoring divider, one quotient bit per clock
module seq_restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] q, d, r;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   s, b;
  logic [WIDTH-1:0] t, r_nxt, q_nxt;
  logic             bw, borrow, accept, last;

  assign accept = start && (state != RUN);
  assign last   = (cnt == CW'(1));

  // Subtract row is WIDTH+1 cells wide because S can reach 2^WIDTH. The kept
  // remainder is always < D, so its top bit is zero and need not be stored.
  always_comb begin
    s  = {r, q[WIDTH-1]};
    b  = {1'b0, d};
    t  = '0;
    bw = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      t[i] = s[i] ^ b[i] ^ bw;
      bw   = (~s[i] & b[i]) | (~(s[i] ^ b[i]) & bw);
    end
    borrow = (~s[WIDTH] & b[WIDTH]) | (~(s[WIDTH] ^ b[WIDTH]) & bw);
    r_nxt  = borrow ? s[WIDTH-1:0] : t;
    q_nxt  = {q[WIDTH-2:0], ~borrow};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b1;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (accept) state_nxt = (divisor == '0) ? DONE : RUN;
      RUN: begin
        ready = 1'b0;
        busy  = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (accept) state_nxt = (divisor == '0) ? DONE : RUN;
        else        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q           <= '0;
      d           <= '0;
      r           <= '0;
      cnt         <= '0;
      div_by_zero <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
    end else if (accept) begin
      q           <= dividend;
      d           <= divisor;
      r           <= '0;
      cnt         <= CW'(WIDTH);
      div_by_zero <= (divisor == '0);
      if (divisor == '0) begin
        quotient  <= '1;
        remainder <= dividend;
      end
    end else if (state == RUN) begin
      q   <= q_nxt;
      r   <= r_nxt;
      cnt <= cnt - CW'(1);
      if (last) begin
        quotient  <= q_nxt;
        remainder <= r_nxt;
      end
    end
  end

endmodule
